lb_arb2: RTL and testbench
==========================

// Module: lb_arb2
// PURPOSE
//  Two-master arbiter/sequencer for the shared local bus (lb_addr/lb_strobe/lb_rd/lb_write/lb_data_out/lb_data_in).
//  Lets a second host (e.g. MMC SPI bridge) share the bus with the packet-badger mailbox host.
//  Each master issues one transaction at a time with a req/ack handshake.
//  The block serialises transactions round-robin, times the fixed read pipeline, and returns read data.
// PARAMETERS
//  AW          24  local-bus address width
//  READ_DELAY  3   cycles from read strobe to valid lb_data_in (>=1)
// PORTS
//  lb_clk       in   1   local-bus clock; sole clock
//  lb_rstn      in   1   reset, asynchronous, active-low
//  m0_req       in   1   master 0 request; held high until m0_ack
//  m0_rd        in   1   1=read, 0=write; stable while m0_req
//  m0_addr      in   AW  address; stable while m0_req
//  m0_wdata     in   32  write data; stable while m0_req
//  m0_ack       out  1   one-cycle completion pulse
//  m0_rdata     out  32  read data; valid with m0_ack, held until next m0 read ack
//  m1_*         --   --  identical set for master 1
//  lb_addr      out  AW  shared bus address
//  lb_strobe    out  1   one-cycle transaction strobe
//  lb_rd        out  1   read qualifier, coincident with lb_strobe
//  lb_write     out  1   write qualifier, coincident with lb_strobe
//  lb_data_out  out  32  write data
//  lb_rd_valid  out  1   high in the cycle lb_data_in is captured
//  lb_data_in   in   32  read data from decoder
//  busy         out  1   high in any state other than IDLE
//  owner        out  1   master currently or last served
// BEHAVIOUR
//  Reset (async assert, sync deassert externally):
//   - FSM goes to IDLE.
//   - All outputs 0: acks, strobes, lb_addr, lb_data_out, rdata, busy, owner.
//   - Round-robin pointer set so m0 has priority.
//   - An in-flight transaction is abandoned with no ack; masters reissue after release.
//  States IDLE, ISSUE, WAIT, DONE; all outputs registered.
//  IDLE:
//   - If any req, grant and latch rd/addr/wdata/owner, then go to ISSUE.
//   - Grant rule: a lone requester wins; if both request, the master not served last wins.
//  ISSUE (1 cycle):
//   - lb_strobe=1, lb_rd=rd, lb_write=~rd; lb_addr/lb_data_out = latched values.
//   - Write goes to DONE; read goes to WAIT with counter=1.
//  WAIT:
//   - Counter increments each cycle.
//   - In the cycle where cycles since the strobe = READ_DELAY: lb_rd_valid=1, capture lb_data_in into owner's rdata, go to DONE.
//   - lb_data_in is ignored in all other cycles.
//   - READ_DELAY=1 means capture in the cycle after ISSUE.
//  DONE (1 cycle):
//   - owner's mN_ack=1, then go to IDLE.
//   - The master must drop req in the cycle after ack; req still high in IDLE is a new request.
//  Latency (strobe at cycle T):
//   - Write: ack at T+1.
//   - Read: lb_rd_valid at T+READ_DELAY, ack at T+READ_DELAY+1.
//   - req to strobe is 1 cycle when idle.
//  Bus hygiene:
//   - lb_strobe/lb_rd/lb_write are 0 outside ISSUE.
//   - lb_addr/lb_data_out hold their last value (no glitch requirement beyond that).
//  The non-owner's req is not sampled until IDLE; the non-owner's ack and rdata are never disturbed.
//  Counter width is clog2(READ_DELAY+1) and never wraps (exit at READ_DELAY).
// TESTING
//  1. m0 write addr 0x000010 data 0xDEADBEEF -> one strobe with lb_write=1, lb_rd=0; m0_ack at T+1; lb_rd_valid stays 0.
//  2. m1 read 0x000200, READ_DELAY=3, bus model returns 0x12345678 at T+3 and 0xBAD00BAD otherwise -> m1_rdata=0x12345678, m1_ack at T+4.
//  3. Both req held continuously after reset -> grants m0,m1,m0,m1; no strobe gaps beyond FSM overhead; never two strobes in consecutive cycles.
//  4. m1 req during m0 read WAIT -> m1 strobe only after m0_ack; m0_rdata unchanged by the m1 transaction.
//  5. lb_rstn low during WAIT -> all outputs 0 immediately (async); no ack; after release, m0 reissues and completes normally.
//  6. READ_DELAY=1 build -> read capture at T+1, ack at T+2; random mixed traffic scoreboarded against a memory model.

Source files
------------

// File: rtl/lb_arb2.sv
// lb_arb2: two-master round-robin sequencer for the shared local bus.
// Each master hands over one transaction at a time with req/ack. The block
// drives a single-cycle strobe, times the fixed read pipeline and returns
// the captured read data to whichever master owns the transaction.
// Every output comes straight from a flop.
module lb_arb2 #(
    parameter int AW         = 24,
    parameter int READ_DELAY = 3
) (
    input  logic          lb_clk,
    input  logic          lb_rstn,
    // master 0
    input  logic          m0_req,
    input  logic          m0_rd,
    input  logic [AW-1:0] m0_addr,
    input  logic [31:0]   m0_wdata,
    output logic          m0_ack,
    output logic [31:0]   m0_rdata,
    // master 1
    input  logic          m1_req,
    input  logic          m1_rd,
    input  logic [AW-1:0] m1_addr,
    input  logic [31:0]   m1_wdata,
    output logic          m1_ack,
    output logic [31:0]   m1_rdata,
    // shared local bus
    output logic [AW-1:0] lb_addr,
    output logic          lb_strobe,
    output logic          lb_rd,
    output logic          lb_write,
    output logic [31:0]   lb_data_out,
    output logic          lb_rd_valid,
    input  logic [31:0]   lb_data_in,
    // status
    output logic          busy,
    output logic          owner
);

    // The counter only has to reach READ_DELAY; it exits there and never wraps.
    localparam int            CW       = $clog2(READ_DELAY + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(READ_DELAY);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;      // cycles since the read strobe
    logic          prio, prio_d;    // master that wins when both request
    logic          cur_rd, cur_rd_d;

    logic          gnt;
    logic          sel_rd;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;

    logic          m0_ack_d, m1_ack_d;
    logic [31:0]   m0_rdata_d, m1_rdata_d;
    logic [AW-1:0] lb_addr_d;
    logic          lb_strobe_d, lb_rd_d, lb_write_d, lb_rd_valid_d;
    logic [31:0]   lb_data_out_d;
    logic          busy_d, owner_d;

    // Pick the winner: a lone requester wins, a tie goes to the master not served last.
    always_comb begin
        gnt       = (m0_req && m1_req) ? prio : m1_req;
        sel_rd    = gnt ? m1_rd    : m0_rd;
        sel_addr  = gnt ? m1_addr  : m0_addr;
        sel_wdata = gnt ? m1_wdata : m0_wdata;
    end

    // Next state and next value of every registered output.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d       = state;
        cnt_d         = cnt;
        prio_d        = prio;
        cur_rd_d      = cur_rd;
        owner_d       = owner;
        lb_addr_d     = lb_addr;
        lb_data_out_d = lb_data_out;
        m0_rdata_d    = m0_rdata;
        m1_rdata_d    = m1_rdata;
        lb_strobe_d   = 1'b0;
        lb_rd_d       = 1'b0;
        lb_write_d    = 1'b0;
        lb_rd_valid_d = 1'b0;
        m0_ack_d      = 1'b0;
        m1_ack_d      = 1'b0;

        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d       = gnt;
                    prio_d        = ~gnt;
                    cur_rd_d      = sel_rd;
                    lb_addr_d     = sel_addr;
                    lb_data_out_d = sel_wdata;
                    lb_strobe_d   = 1'b1;
                    lb_rd_d       = sel_rd;
                    lb_write_d    = ~sel_rd;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                if (cur_rd) begin
                    cnt_d         = CNT_ONE;
                    lb_rd_valid_d = (READ_DELAY == 1);
                    state_d       = WAIT;
                end else begin
                    m0_ack_d = ~owner;
                    m1_ack_d = owner;
                    state_d  = DONE;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    if (owner) m1_rdata_d = lb_data_in;
                    else       m0_rdata_d = lb_data_in;
                    m0_ack_d = ~owner;
                    m1_ack_d = owner;
                    state_d  = DONE;
                end else begin
                    cnt_d         = cnt + CNT_ONE;
                    lb_rd_valid_d = ((cnt + CNT_ONE) == CNT_LAST);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge lb_clk or negedge lb_rstn) begin
        if (!lb_rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            prio        <= 1'b0;
            cur_rd      <= 1'b0;
            owner       <= 1'b0;
            lb_addr     <= '0;
            lb_data_out <= '0;
            lb_strobe   <= 1'b0;
            lb_rd       <= 1'b0;
            lb_write    <= 1'b0;
            lb_rd_valid <= 1'b0;
            m0_ack      <= 1'b0;
            m1_ack      <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            busy        <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so all flops see pre-edge values.
            state       <= state_d;
            cnt         <= cnt_d;
            prio        <= prio_d;
            cur_rd      <= cur_rd_d;
            owner       <= owner_d;
            lb_addr     <= lb_addr_d;
            lb_data_out <= lb_data_out_d;
            lb_strobe   <= lb_strobe_d;
            lb_rd       <= lb_rd_d;
            lb_write    <= lb_write_d;
            lb_rd_valid <= lb_rd_valid_d;
            m0_ack      <= m0_ack_d;
            m1_ack      <= m1_ack_d;
            m0_rdata    <= m0_rdata_d;
            m1_rdata    <= m1_rdata_d;
            busy        <= busy_d;
        end
    end

endmodule

// File: tb/tb_lb_arb2.sv
// tb_lb_arb2: directed bench for lb_arb2. Instance "a" uses READ_DELAY=3,
// instance "b" uses READ_DELAY=1; each has its own simple bus slave.
module tb_lb_arb2;

    localparam int AW = 24;

    logic lb_clk  = 1'b0;
    logic lb_rstn = 1'b0;
    always #5 lb_clk = ~lb_clk;

    int checks = 0;
    int errors = 0;

    // ---------------- instance a (READ_DELAY = 3) ----------------
    logic          a_m0_req, a_m0_rd, a_m0_ack, a_m1_req, a_m1_rd, a_m1_ack;
    logic [AW-1:0] a_m0_addr, a_m1_addr, a_lb_addr;
    logic [31:0]   a_m0_wdata, a_m0_rdata, a_m1_wdata, a_m1_rdata;
    logic          a_lb_strobe, a_lb_rd, a_lb_write, a_lb_rd_valid, a_busy, a_owner;
    logic [31:0]   a_lb_data_out, a_lb_data_in;

    lb_arb2 #(.AW(AW), .READ_DELAY(3)) dut_a (
        .lb_clk(lb_clk), .lb_rstn(lb_rstn),
        .m0_req(a_m0_req), .m0_rd(a_m0_rd), .m0_addr(a_m0_addr), .m0_wdata(a_m0_wdata),
        .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
        .m1_req(a_m1_req), .m1_rd(a_m1_rd), .m1_addr(a_m1_addr), .m1_wdata(a_m1_wdata),
        .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
        .lb_addr(a_lb_addr), .lb_strobe(a_lb_strobe), .lb_rd(a_lb_rd), .lb_write(a_lb_write),
        .lb_data_out(a_lb_data_out), .lb_rd_valid(a_lb_rd_valid), .lb_data_in(a_lb_data_in),
        .busy(a_busy), .owner(a_owner)
    );

    // ---------------- instance b (READ_DELAY = 1) ----------------
    logic          b_m0_req, b_m0_rd, b_m0_ack, b_m1_req, b_m1_rd, b_m1_ack;
    logic [AW-1:0] b_m0_addr, b_m1_addr, b_lb_addr;
    logic [31:0]   b_m0_wdata, b_m0_rdata, b_m1_wdata, b_m1_rdata;
    logic          b_lb_strobe, b_lb_rd, b_lb_write, b_lb_rd_valid, b_busy, b_owner;
    logic [31:0]   b_lb_data_out, b_lb_data_in;

    lb_arb2 #(.AW(AW), .READ_DELAY(1)) dut_b (
        .lb_clk(lb_clk), .lb_rstn(lb_rstn),
        .m0_req(b_m0_req), .m0_rd(b_m0_rd), .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata),
        .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
        .m1_req(b_m1_req), .m1_rd(b_m1_rd), .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata),
        .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
        .lb_addr(b_lb_addr), .lb_strobe(b_lb_strobe), .lb_rd(b_lb_rd), .lb_write(b_lb_write),
        .lb_data_out(b_lb_data_out), .lb_rd_valid(b_lb_rd_valid), .lb_data_in(b_lb_data_in),
        .busy(b_busy), .owner(b_owner)
    );

    // Bus slave a: word memory, read data valid only 3 cycles after the read strobe.
    logic [31:0] mem_a [0:255];
    logic [3:0]  age_a;
    logic [7:0]  ridx_a;
    logic        pl_en;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;
    always @(posedge lb_clk) begin
        if (pl_en) mem_a[pl_idx] <= pl_data;
        else if (a_lb_strobe && a_lb_write) mem_a[a_lb_addr[9:2]] <= a_lb_data_out;
        if (!lb_rstn) age_a <= 4'd0;
        else if (a_lb_strobe && a_lb_rd) begin
            age_a  <= 4'd1;
            ridx_a <= a_lb_addr[9:2];
        end else if (age_a != 4'd0 && age_a != 4'hF) age_a <= age_a + 4'd1;
    end
    assign a_lb_data_in = (age_a == 4'd3) ? mem_a[ridx_a] : 32'hBAD0_0BAD;

    // Bus slave b: same shape, read data valid 1 cycle after the strobe.
    logic [31:0] mem_b [0:255];
    logic [3:0]  age_b;
    logic [7:0]  ridx_b;
    always @(posedge lb_clk) begin
        if (b_lb_strobe && b_lb_write) mem_b[b_lb_addr[9:2]] <= b_lb_data_out;
        if (!lb_rstn) age_b <= 4'd0;
        else if (b_lb_strobe && b_lb_rd) begin
            age_b  <= 4'd1;
            ridx_b <= b_lb_addr[9:2];
        end else if (age_b != 4'd0 && age_b != 4'hF) age_b <= age_b + 4'd1;
    end
    assign b_lb_data_in = (age_b == 4'd1) ? mem_b[ridx_b] : 32'hBAD0_0BAD;

    // Scoreboard state for instance b.
    logic [31:0] ref_b  [0:7];
    logic [31:0] last_b [0:1];

    task automatic tick();
        @(posedge lb_clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pl_en = 1'b1; pl_idx = idx; pl_data = data;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic check_a_all_zero(input string tag);
        checks++;
        if ({a_m0_ack, a_m1_ack, a_lb_strobe, a_lb_rd, a_lb_write, a_lb_rd_valid, a_busy, a_owner} !== 8'h00) begin
            errors++;
            $display("FAIL %s_flags got %b exp 00000000", tag,
                     {a_m0_ack, a_m1_ack, a_lb_strobe, a_lb_rd, a_lb_write, a_lb_rd_valid, a_busy, a_owner});
        end
        checks++;
        if ({a_lb_addr, a_lb_data_out, a_m0_rdata, a_m1_rdata} !== '0) begin
            errors++;
            $display("FAIL %s_data got addr=%h dout=%h r0=%h r1=%h exp all 0", tag,
                     a_lb_addr, a_lb_data_out, a_m0_rdata, a_m1_rdata);
        end
    endtask

    task automatic test_reset();
        repeat (2) tick();
        check_a_all_zero("rst");
        checks++;
        if ({b_busy, b_owner, b_lb_strobe, b_m0_ack, b_m1_ack, b_m0_rdata, b_m1_rdata} !== '0) begin
            errors++;
            $display("FAIL rst_b got busy=%b owner=%b strobe=%b r0=%h r1=%h exp 0",
                     b_busy, b_owner, b_lb_strobe, b_m0_rdata, b_m1_rdata);
        end
        lb_rstn = 1'b1;
        tick();
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_idle got busy=%b exp 0", a_busy); end
    endtask

    // m0 write: one strobe with lb_write, ack one cycle later, no rd_valid.
    task automatic test_write();
        a_m0_rd = 1'b0; a_m0_addr = 24'h000010; a_m0_wdata = 32'hDEAD_BEEF; a_m0_req = 1'b1;
        tick();
        checks++;
        if ({a_lb_strobe, a_lb_rd, a_lb_write, a_owner, a_busy, a_m0_ack} !== 6'b101010) begin
            errors++;
            $display("FAIL wr_issue got str/rd/wr/own/busy/ack=%b exp 101010",
                     {a_lb_strobe, a_lb_rd, a_lb_write, a_owner, a_busy, a_m0_ack});
        end
        checks++;
        if (a_lb_addr !== 24'h000010 || a_lb_data_out !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL wr_bus got addr=%h dout=%h exp 000010 deadbeef", a_lb_addr, a_lb_data_out);
        end
        tick();
        checks++;
        if ({a_m0_ack, a_m1_ack, a_lb_strobe, a_lb_rd_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL wr_ack got ack0/ack1/str/rv=%b exp 1000", {a_m0_ack, a_m1_ack, a_lb_strobe, a_lb_rd_valid});
        end
        a_m0_req = 1'b0;
        tick();
        checks++;
        if ({a_m0_ack, a_busy, a_lb_strobe, a_lb_rd_valid} !== 4'b0000 || a_lb_addr !== 24'h000010) begin
            errors++;
            $display("FAIL wr_idle got ack/busy/str/rv=%b addr=%h exp 0000 000010",
                     {a_m0_ack, a_busy, a_lb_strobe, a_lb_rd_valid}, a_lb_addr);
        end
    endtask

    // m1 read: rd_valid at T+3 only, ack and rdata at T+4.
    task automatic test_read();
        preload(8'h80, 32'h1234_5678);
        a_m1_rd = 1'b1; a_m1_addr = 24'h000200; a_m1_wdata = 32'h0; a_m1_req = 1'b1;
        tick();
        checks++;
        if ({a_lb_strobe, a_lb_rd, a_lb_write, a_owner} !== 4'b1101 || a_lb_addr !== 24'h000200) begin
            errors++;
            $display("FAIL rd_issue got str/rd/wr/own=%b addr=%h exp 1101 000200",
                     {a_lb_strobe, a_lb_rd, a_lb_write, a_owner}, a_lb_addr);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if ({a_lb_rd_valid, a_lb_strobe, a_m1_ack} !== {(k == 3), 2'b00}) begin
                errors++;
                $display("FAIL rd_wait%0d got rv/str/ack=%b exp %b", k,
                         {a_lb_rd_valid, a_lb_strobe, a_m1_ack}, {(k == 3), 2'b00});
            end
        end
        tick();
        checks++;
        if (a_m1_ack !== 1'b1 || a_m1_rdata !== 32'h1234_5678 || a_m0_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rd_ack got ack=%b r1=%h r0=%h exp 1 12345678 0", a_m1_ack, a_m1_rdata, a_m0_rdata);
        end
        a_m1_req = 1'b0;
        tick();
        checks++;
        if ({a_m1_ack, a_busy} !== 2'b00) begin
            errors++; $display("FAIL rd_idle got ack/busy=%b exp 00", {a_m1_ack, a_busy});
        end
    endtask

    // Both masters request continuously from reset: grants alternate m0,m1,...
    task automatic test_back_to_back();
        int n;
        int last;
        lb_rstn = 1'b0;
        repeat (2) tick();
        a_m0_rd = 1'b0; a_m0_addr = 24'h000020; a_m0_wdata = 32'h1111_1111; a_m0_req = 1'b1;
        a_m1_rd = 1'b0; a_m1_addr = 24'h000030; a_m1_wdata = 32'h2222_2222; a_m1_req = 1'b1;
        lb_rstn = 1'b1;
        n = 0;
        last = 0;
        for (int c = 1; c <= 30 && n < 4; c++) begin
            tick();
            if (a_lb_strobe === 1'b1) begin
                checks++;
                if (a_owner !== n[0] || a_lb_addr !== (n[0] ? 24'h000030 : 24'h000020)) begin
                    errors++;
                    $display("FAIL b2b_grant%0d got owner=%b addr=%h exp owner=%b", n, a_owner, a_lb_addr, n[0]);
                end
                checks++;
                if (c - last !== ((n == 0) ? 1 : 3)) begin
                    errors++;
                    $display("FAIL b2b_gap%0d got %0d exp %0d", n, c - last, (n == 0) ? 1 : 3);
                end
                last = c;
                n++;
            end
        end
        checks++;
        if (n !== 4) begin errors++; $display("FAIL b2b_count got %0d strobes exp 4", n); end
        tick();
        checks++;
        if ({a_m1_ack, a_m0_ack} !== 2'b10) begin
            errors++; $display("FAIL b2b_last_ack got ack1/ack0=%b exp 10", {a_m1_ack, a_m0_ack});
        end
        a_m0_req = 1'b0;
        a_m1_req = 1'b0;
        repeat (2) tick();
        checks++;
        if ({a_busy, a_lb_strobe} !== 2'b00) begin
            errors++; $display("FAIL b2b_idle got busy/str=%b exp 00", {a_busy, a_lb_strobe});
        end
    endtask

    // m1 request arrives during m0's read wait: m1 strobes only after m0_ack.
    task automatic test_overlap();
        preload(8'h10, 32'hCAFE_F00D);
        preload(8'h12, 32'hA5A5_A5A5);
        a_m0_rd = 1'b1; a_m0_addr = 24'h000040; a_m0_req = 1'b1;
        tick();
        tick();
        a_m1_rd = 1'b1; a_m1_addr = 24'h000048; a_m1_req = 1'b1;
        for (int k = 2; k <= 3; k++) begin
            tick();
            checks++;
            if (a_lb_strobe !== 1'b0) begin errors++; $display("FAIL ovl_nostrobe%0d got %b exp 0", k, a_lb_strobe); end
        end
        tick();
        checks++;
        if (a_m0_ack !== 1'b1 || a_m0_rdata !== 32'hCAFE_F00D || a_lb_strobe !== 1'b0) begin
            errors++;
            $display("FAIL ovl_m0_ack got ack=%b r0=%h str=%b exp 1 cafef00d 0", a_m0_ack, a_m0_rdata, a_lb_strobe);
        end
        a_m0_req = 1'b0;
        tick();
        checks++;
        if ({a_lb_strobe, a_m0_ack} !== 2'b00) begin
            errors++; $display("FAIL ovl_idle got str/ack=%b exp 00", {a_lb_strobe, a_m0_ack});
        end
        tick();
        checks++;
        if ({a_lb_strobe, a_owner} !== 2'b11 || a_lb_addr !== 24'h000048) begin
            errors++;
            $display("FAIL ovl_m1_issue got str/own=%b addr=%h exp 11 000048", {a_lb_strobe, a_owner}, a_lb_addr);
        end
        repeat (4) tick();
        checks++;
        if (a_m1_ack !== 1'b1 || a_m1_rdata !== 32'hA5A5_A5A5 || a_m0_rdata !== 32'hCAFE_F00D || a_m0_ack !== 1'b0) begin
            errors++;
            $display("FAIL ovl_m1_ack got ack1=%b r1=%h r0=%h ack0=%b exp 1 a5a5a5a5 cafef00d 0",
                     a_m1_ack, a_m1_rdata, a_m0_rdata, a_m0_ack);
        end
        a_m1_req = 1'b0;
        tick();
    endtask

    // Reset mid-WAIT clears everything at once; the reissued read completes normally.
    task automatic test_reset_in_wait();
        a_m0_rd = 1'b1; a_m0_addr = 24'h000040; a_m0_req = 1'b1;
        repeat (3) tick();
        checks++;
        if (a_busy !== 1'b1) begin errors++; $display("FAIL rw_busy got %b exp 1", a_busy); end
        #2;
        lb_rstn = 1'b0;
        #1;
        check_a_all_zero("rw_async");
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({a_m0_ack, a_busy} !== 2'b00) begin
                errors++; $display("FAIL rw_held%0d got ack/busy=%b exp 00", k, {a_m0_ack, a_busy});
            end
        end
        lb_rstn = 1'b1;
        tick();
        checks++;
        if ({a_lb_strobe, a_lb_rd, a_owner} !== 3'b110 || a_lb_addr !== 24'h000040) begin
            errors++;
            $display("FAIL rw_reissue got str/rd/own=%b addr=%h exp 110 000040", {a_lb_strobe, a_lb_rd, a_owner}, a_lb_addr);
        end
        repeat (4) tick();
        checks++;
        if (a_m0_ack !== 1'b1 || a_m0_rdata !== 32'hCAFE_F00D || a_m1_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rw_done got ack=%b r0=%h r1=%h exp 1 cafef00d 0", a_m0_ack, a_m0_rdata, a_m1_rdata);
        end
        a_m0_req = 1'b0;
        tick();
    endtask

    // One transaction on instance b with latency and rdata checks.
    task automatic txn_b(input logic m, input logic rd, input logic [AW-1:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
        int lat;
        int rv_at;
        if (m) begin
            b_m1_rd = rd; b_m1_addr = addr; b_m1_wdata = wdata; b_m1_req = 1'b1;
        end else begin
            b_m0_rd = rd; b_m0_addr = addr; b_m0_wdata = wdata; b_m0_req = 1'b1;
        end
        tick();
        checks++;
        if ({b_lb_strobe, b_lb_rd, b_lb_write, b_owner} !== {1'b1, rd, ~rd, m} || b_lb_addr !== addr) begin
            errors++;
            $display("FAIL rd1_issue got str/rd/wr/own=%b addr=%h exp %b %h",
                     {b_lb_strobe, b_lb_rd, b_lb_write, b_owner}, b_lb_addr, {1'b1, rd, ~rd, m}, addr);
        end
        lat = -1;
        rv_at = -1;
        for (int c = 1; c <= 6 && lat < 0; c++) begin
            tick();
            if (b_lb_rd_valid === 1'b1 && rv_at < 0) rv_at = c;
            if ((m ? b_m1_ack : b_m0_ack) === 1'b1) lat = c;
        end
        b_m0_req = 1'b0;
        b_m1_req = 1'b0;
        checks++;
        if (lat !== (rd ? 2 : 1)) begin
            errors++; $display("FAIL rd1_ack_latency got %0d exp %0d (-1 = no ack)", lat, rd ? 2 : 1);
        end
        checks++;
        if (rv_at !== (rd ? 1 : -1)) begin
            errors++; $display("FAIL rd1_valid_at got %0d exp %0d", rv_at, rd ? 1 : -1);
        end
        if (rd) last_b[m] = exp_rdata;
        checks++;
        if (b_m0_rdata !== last_b[0] || b_m1_rdata !== last_b[1]) begin
            errors++;
            $display("FAIL rd1_rdata got r0=%h r1=%h exp r0=%h r1=%h", b_m0_rdata, b_m1_rdata, last_b[0], last_b[1]);
        end
        tick();
    endtask

    // READ_DELAY=1 build: fill a small region, then mixed random traffic vs. a reference memory.
    task automatic test_read_delay1();
        logic        m;
        logic        rd;
        int          i;
        logic [31:0] d;
        last_b[0] = 32'h0;
        last_b[1] = 32'h0;
        for (int k = 0; k < 8; k++) begin
            ref_b[k] = 32'h0F0F_0000 + 32'(k);
            txn_b(k[0], 1'b0, 24'h000100 + 24'(k * 4), ref_b[k], 32'h0);
        end
        txn_b(1'b0, 1'b1, 24'h000100, 32'h0, ref_b[0]);
        for (int t = 0; t < 24; t++) begin
            m  = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            i  = int'($urandom_range(0, 7));
            d  = $urandom;
            if (rd) txn_b(m, 1'b1, 24'h000100 + 24'(i * 4), 32'h0, ref_b[i]);
            else begin
                txn_b(m, 1'b0, 24'h000100 + 24'(i * 4), d, 32'h0);
                ref_b[i] = d;
            end
        end
    endtask

    initial begin
        a_m0_req = 1'b0; a_m0_rd = 1'b0; a_m0_addr = '0; a_m0_wdata = '0;
        a_m1_req = 1'b0; a_m1_rd = 1'b0; a_m1_addr = '0; a_m1_wdata = '0;
        b_m0_req = 1'b0; b_m0_rd = 1'b0; b_m0_addr = '0; b_m0_wdata = '0;
        b_m1_req = 1'b0; b_m1_rd = 1'b0; b_m1_addr = '0; b_m1_wdata = '0;
        pl_en = 1'b0; pl_idx = '0; pl_data = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_overlap();
        test_reset_in_wait();
        test_read_delay1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
